// File: rtl/nth_root_fx.sv
// nth_root_fx: fixed-point n-th root, floor(x^(1/n) * 2^FRAC_W).
// Restoring bit-by-bit search. Each candidate is raised to the n-th power
// with repeated multiplies, and the power is compared exactly against
// x << (n*FRAC_W). Power evaluation stops early once the partial product
// passes the target. n=0 is reported as an error and n=1 is passed straight
// through.
module nth_root_fx #(
  parameter int IN_W     = 10,
  parameter int EXP_W    = 3,
  parameter int FRAC_W   = 5,
  localparam int OUT_W   = IN_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data_1,
  input  logic [EXP_W-1:0] in_data_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int NMAX  = (1 << EXP_W) - 1;
  localparam int T_W   = IN_W + NMAX * FRAC_W;
  localparam int ACC_W = NMAX * OUT_W;
  localparam int P_W   = ACC_W + OUT_W;

  typedef enum logic [2:0] {IDLE, TRY, MUL, CMP, DONE} state_t;

  state_t             state_q, state_nxt;
  logic [EXP_W-1:0]   n_q;
  logic [T_W-1:0]     target_q;
  logic [OUT_W-1:0]   bit_q;
  logic [OUT_W-1:0]   trial_q;
  logic [OUT_W-1:0]   result_q;
  logic [P_W-1:0]     acc_q;
  logic [EXP_W-1:0]   cnt_q;
  logic               err_q;

  logic [P_W-1:0]     target_ext;
  logic               acc_over;
  logic               last_mul;
  logic               full_pow;
  logic               exact;

  // Target scaled so the integer root of it carries FRAC_W fractional bits.
  function automatic logic [T_W-1:0] target_of(input logic [IN_W-1:0]  x,
                                               input logic [EXP_W-1:0] n);
    logic [T_W-1:0] t;
    t = T_W'(x);
    return t << (int'(n) * FRAC_W);
  endfunction

  assign target_ext = P_W'(target_q);
  assign acc_over   = acc_q > target_ext;
  assign last_mul   = (cnt_q + EXP_W'(1)) == n_q;
  assign full_pow   = cnt_q == n_q;
  assign exact      = full_pow && (acc_q == target_ext);
  assign in_ready   = (state_q == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic. The multiply loop exits on the registered count or on
  // a partial product already above the target.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (in_valid)
              state_nxt = (in_data_2 == '0 || in_data_2 == EXP_W'(1)) ? DONE : TRY;
      TRY:  state_nxt = MUL;
      MUL:  if (acc_over || last_mul) state_nxt = CMP;
      CMP:  state_nxt = (exact || bit_q[0]) ? DONE : TRY;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit search datapath and registered result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      target_q  <= '0;
      bit_q     <= '0;
      trial_q   <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          n_q      <= in_data_2;
          target_q <= target_of(in_data_1, in_data_2);
          err_q    <= (in_data_2 == '0);
          bit_q    <= OUT_W'(1) << (OUT_W - 1);
          result_q <= (in_data_2 == EXP_W'(1)) ? (OUT_W'(in_data_1) << FRAC_W) : '0;
        end
        TRY: begin
          trial_q <= result_q | bit_q;
          acc_q   <= P_W'(result_q | bit_q);
          cnt_q   <= EXP_W'(1);
        end
        // Multiply only while the partial product is still within the target,
        // so the product never exceeds T_W + OUT_W bits.
        MUL: if (!acc_over) begin
          acc_q <= acc_q * P_W'(trial_q);
          cnt_q <= cnt_q + EXP_W'(1);
        end
        CMP: begin
          if (full_pow && (acc_q <= target_ext)) result_q <= trial_q;
          if (!exact && !bit_q[0]) bit_q <= bit_q >> 1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= result_q;
            out_err   <= err_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nth_root_fx.md
Name: nth_root_fx

Overview:
Parametrised fixed-point n-th root engine, the successor to the team's 10-bit/3-bit root block. Given unsigned integer x and exponent n, it returns floor(x^(1/n) * 2^FRAC_W) by restoring bit-by-bit search with exact power comparison.
Adds valid/ready handshakes on both sides, an error path for n=0, a direct n=1 path, and early abort of power evaluation once the partial product exceeds the target. Sits in the arithmetic datapath beside the divider.

Parameters:
IN_W, 10, width of radicand x (unsigned integer)
EXP_W, 3, width of exponent n; NMAX = 2^EXP_W-1
FRAC_W, 5, fractional bits of the result
OUT_W, IN_W+FRAC_W, result width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  operand valid
in_ready  out  1  engine idle, can accept operands
in_data_1  in  IN_W  radicand x
in_data_2  in  EXP_W  exponent n
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  root, unsigned, FRAC_W fractional bits
out_err  out  1  qualified by out_valid; 1 when n=0

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; in_ready=1, out_valid=0, out_data=0, out_err=0; all internal registers 0. Reset mid-operation aborts the computation, and no out_valid follows.
- Accept: in_valid&in_ready at a rising edge latches x, n; in_ready drops the next cycle. in_ready=1 only in IDLE; no overlapped operations.
- Target T = x << (n*FRAC_W), width IN_W+NMAX*FRAC_W. Accumulator and product are computed at full width ACC_W+OUT_W (ACC_W=NMAX*OUT_W). No truncation anywhere.
- States: IDLE, TRY, MUL, CMP, DONE.
- IDLE -> DONE when n=0: result=0, err=1.
- IDLE -> DONE when n=1: result = x<<FRAC_W, err=0.
- IDLE -> TRY otherwise: bit = MSB of OUT_W, result=0.
- TRY (1 cycle): trial=result|bit; acc=trial; cnt=1.
- MUL: each cycle acc<=acc*trial, cnt<=cnt+1. Leave to CMP when cnt==n or acc>T, evaluated on the registered values, so early abort skips the remaining multiplies.
- CMP (1 cycle):
  - If cnt==n and acc<=T, result<=trial.
  - If cnt==n and acc==T, go to DONE (exact match, remaining bits 0).
  - Else if bit is the LSB, go to DONE.
  - Else bit>>=1 and go to TRY.
- DONE: out_valid=1, out_data=result, out_err=err. Registered and stable while out_ready=0. Return to IDLE on out_valid&out_ready; that same edge clears out_valid and out_data to 0.
- Latency from accept edge to out_valid:
  - n=0 or n=1: 2 cycles.
  - n>=2: at most OUT_W*(n+1)+2 cycles.
  - Fewer cycles with aborts or an exact match.
- x=0 with n>=2: every trial aborts or fails, so result=0 and err=0.
- in_valid while busy is ignored (in_ready=0). No operands are dropped silently beyond this.
- Simultaneous out_ready and in_valid in DONE: only the output is consumed. The next accept happens in IDLE.

Test Plan:
- x=2, n=2 -> out_data=45 (0x2D, 1.40625), out_err=0, within 15*3+2 cycles.
- x=1000, n=3 -> out_data=320 (10.0). Exact-match early DONE: latency strictly less than the full 15-bit search.
- x=1023, n=7 -> out_data=86. Check that no product wraps: 87^7 > T aborts.
- x=5, n=0 -> out_err=1, out_data=0, 2 cycles. x=1023, n=1 -> out_data=32736, 2 cycles.
- x=2, n=2 with out_ready low for 5 cycles -> out_valid and out_data=45 stable; in_ready=0 and an in_valid pulse is ignored. Handshake completes on out_ready, then in_ready=1.
- x=1000, n=3, assert rst_n=0 mid-MUL -> outputs are at reset values immediately, with no out_valid. Then x=0, n=4 -> out_data=0, out_err=0.
